// File: rtl/handshake_arbiter_ctrl_pkg.sv
// Shared types and constant helpers for the multi-channel handshake arbiter.
package handshake_arbiter_ctrl_pkg;

  // Controller state encoding; values are fixed so traces stay readable.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ACCEPTING  = 3'd1,
    PROCESSING = 3'd2,
    DONE       = 3'd3,
    ABORT      = 3'd4
  } state_t;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return result;
  endfunction

  // Larger of two integers, usable in parameter expressions.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/handshake_arbiter_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first requesting channel at or after
// rr_ptr, wrapping around the channel count.
module rr_arbiter
  import handshake_arbiter_ctrl_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int ID_W   = max_int(clog2(NUM_CH), 1)
) (
  input  logic [NUM_CH-1:0] request,
  input  logic [ID_W-1:0]   rr_ptr,
  output logic              valid,
  output logic [ID_W-1:0]   winner
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down so the closest requester to rr_ptr wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = ID_W'((int'(rr_ptr) + i) % NUM_CH);
      if (request[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/handshake_arbiter_ctrl.sv
// Multi-channel request/accept/done controller with round-robin arbitration,
// stallable processing phase and accept-phase timeout.
module handshake_arbiter_ctrl
  import handshake_arbiter_ctrl_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int PROC_CYCLES = 4,
  parameter  int TIMEOUT     = 16,
  localparam int ID_W        = max_int(clog2(NUM_CH), 1),
  localparam int CNT_W       = clog2(max_int(PROC_CYCLES, TIMEOUT)) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] request,
  input  logic              stall,
  output logic [NUM_CH-1:0] accept,
  output logic [NUM_CH-1:0] done,
  output logic              timeout,
  output logic              busy,
  output logic [ID_W-1:0]   grant_id
);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  proc_cnt;
  logic              arb_valid;
  logic [ID_W-1:0]   arb_winner;
  logic [ID_W-1:0]   next_ptr;
  logic [NUM_CH-1:0] grant_onehot;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .request (request),
    .rr_ptr  (rr_ptr),
    .valid   (arb_valid),
    .winner  (arb_winner)
  );

  assign next_ptr     = (arb_winner == ID_W'(NUM_CH - 1)) ? '0 : arb_winner + ID_W'(1);
  assign grant_onehot = NUM_CH'(1) << grant_id;

  // Controller FSM with grant bookkeeping and the wait/processing counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      wait_cnt <= '0;
      proc_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_id <= arb_winner;
            rr_ptr   <= next_ptr;
            wait_cnt <= '0;
            state    <= ACCEPTING;
          end
        end
        ACCEPTING: begin
          if (!request[grant_id]) begin
            proc_cnt <= CNT_W'(PROC_CYCLES - 1);
            state    <= PROCESSING;
          end else if ((TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1))) begin
            state <= ABORT;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        PROCESSING: begin
          if (!stall) begin
            if (proc_cnt == '0) begin
              state <= DONE;
            end else begin
              proc_cnt <= proc_cnt - CNT_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore output decode from the registered state and grant.
  always_comb begin
    accept  = '0;
    done    = '0;
    timeout = 1'b0;
    busy    = (state != IDLE);
    case (state)
      ACCEPTING: accept  = grant_onehot;
      DONE:      done    = grant_onehot;
      ABORT:     timeout = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_handshake_arbiter_ctrl.sv
// Directed bench for handshake_arbiter_ctrl: vector table plus multi-cycle
// corner-case sequences (stall, timeout, drop/timeout tie, mid-run reset).
module tb_handshake_arbiter_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] request;
  logic       stall;
  logic [3:0] accept;
  logic [3:0] done;
  logic       timeout;
  logic       busy;
  logic [1:0] grant_id;

  int cmp_count;
  int fail_count;

  typedef struct {
    logic       rst;
    logic [3:0] request;
    logic       stall;
    logic [3:0] exp_accept;
    logic [3:0] exp_done;
    logic       exp_timeout;
    logic       exp_busy;
    logic [1:0] exp_gid;
  } vec_t;

  vec_t vecs[$];

  handshake_arbiter_ctrl #(
    .NUM_CH      (4),
    .PROC_CYCLES (4),
    .TIMEOUT     (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .request  (request),
    .stall    (stall),
    .accept   (accept),
    .done     (done),
    .timeout  (timeout),
    .busy     (busy),
    .grant_id (grant_id)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic addVec(input logic r, input logic [3:0] req, input logic st,
                        input logic [3:0] e_acc, input logic [3:0] e_done,
                        input logic e_to, input logic e_busy, input logic [1:0] e_gid);
    vec_t v;
    v.rst = r; v.request = req; v.stall = st;
    v.exp_accept = e_acc; v.exp_done = e_done; v.exp_timeout = e_to;
    v.exp_busy = e_busy; v.exp_gid = e_gid;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] req, input logic st);
    rst     = r;
    request = req;
    stall   = st;
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    cmp_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_acc, input logic [3:0] e_done,
                             input logic e_to, input logic e_busy, input logic [1:0] e_gid);
    checkValue({name, " accept"},   32'(accept),   32'(e_acc));
    checkValue({name, " done"},     32'(done),     32'(e_done));
    checkValue({name, " timeout"},  32'(timeout),  32'(e_to));
    checkValue({name, " busy"},     32'(busy),     32'(e_busy));
    checkValue({name, " grant_id"}, 32'(grant_id), 32'(e_gid));
  endtask

  initial begin
    logic [3:0] oh;
    logic [3:0] rest;
    int         cycles;
    int         acc_cnt;
    bit         to_seen;
    bit         done_seen;

    cmp_count  = 0;
    fail_count = 0;
    rst        = 1'b0;
    request    = '0;
    stall      = 1'b0;

    // Reset state, then a single channel-2 transaction.
    addVec(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);
    addVec(1, 4'b0100, 0, 4'b0100, 4'b0000, 0, 1, 2'd2);
    addVec(1, 4'b0100, 0, 4'b0100, 4'b0000, 0, 1, 2'd2);
    addVec(1, 4'b0100, 0, 4'b0100, 4'b0000, 0, 1, 2'd2);
    for (int k = 0; k < 4; k++) addVec(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 2'd2);
    addVec(1, 4'b0000, 0, 4'b0000, 4'b0100, 0, 1, 2'd2);
    addVec(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 2'd2);

    // Round robin with all channels requesting: grant order 0,1,2,3,0.
    addVec(0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 2'd0);
    for (int t = 0; t < 5; t++) begin
      oh = '0;
      oh[t % 4] = 1'b1;
      rest = 4'b1111 & ~oh;
      addVec(1, 4'b1111, 0, oh, 4'b0000, 0, 1, 2'(t % 4));
      addVec(1, 4'b1111, 0, oh, 4'b0000, 0, 1, 2'(t % 4));
      for (int k = 0; k < 4; k++) addVec(1, rest, 0, 4'b0000, 4'b0000, 0, 1, 2'(t % 4));
      addVec(1, rest, 0, 4'b0000, oh, 0, 1, 2'(t % 4));
      addVec(1, 4'b1111, 0, 4'b0000, 4'b0000, 0, 0, 2'(t % 4));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].request, vecs[i].stall);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_accept, vecs[i].exp_done,
                  vecs[i].exp_timeout, vecs[i].exp_busy, vecs[i].exp_gid);
    end

    // Stall: five stalled cycles with the counter parked at 2.
    applyStimulus(0, 4'b0000, 0);
    applyStimulus(1, 4'b0001, 0);
    applyStimulus(1, 4'b0001, 0);
    applyStimulus(1, 4'b0000, 0);
    checkOutput("stall_enter", 4'b0000, 4'b0000, 0, 1, 2'd0);
    applyStimulus(1, 4'b0000, 0);
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1, 4'b0000, 1);
      checkValue($sformatf("stall_cnt%0d", n), 32'(dut.proc_cnt), 32'd2);
      checkValue($sformatf("stall_done%0d", n), 32'(done), 32'd0);
    end
    cycles = 0;
    while (done == 4'b0000 && cycles < 20) begin
      applyStimulus(1, 4'b0000, 0);
      cycles++;
    end
    checkValue("stall_release_to_done", 32'(cycles), 32'd3);
    checkValue("stall_done_value", 32'(done), 32'b0001);
    applyStimulus(1, 4'b0000, 0);
    checkValue("stall_idle_busy", 32'(busy), 32'd0);

    // Timeout: channel 1 never drops, channel 3 waits behind it.
    applyStimulus(0, 4'b0000, 0);
    acc_cnt   = 0;
    to_seen   = 0;
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1, 4'b1010, 0);
      if (accept == 4'b0010) acc_cnt++;
      if (done != 4'b0000) done_seen = 1;
      if (timeout) begin
        to_seen = 1;
        break;
      end
    end
    checkValue("to_accept_cycles", 32'(acc_cnt), 32'd16);
    checkValue("to_pulse_seen", 32'(to_seen), 32'd1);
    checkValue("to_no_done", 32'(done_seen), 32'd0);
    checkOutput("to_abort", 4'b0000, 4'b0000, 1, 1, 2'd1);
    applyStimulus(1, 4'b1010, 0);
    checkOutput("to_idle", 4'b0000, 4'b0000, 0, 0, 2'd1);
    applyStimulus(1, 4'b1010, 0);
    checkOutput("to_next_grant", 4'b1000, 4'b0000, 0, 1, 2'd3);
    applyStimulus(1, 4'b0010, 0);
    for (int k = 0; k < 4; k++) applyStimulus(1, 4'b0010, 0);
    checkOutput("to_ch3_done", 4'b0000, 4'b1000, 0, 1, 2'd3);

    // Tie: request drops on the edge the timeout limit would trigger.
    applyStimulus(0, 4'b0000, 0);
    for (int n = 0; n < 16; n++) applyStimulus(1, 4'b0001, 0);
    checkOutput("tie_last_accept", 4'b0001, 4'b0000, 0, 1, 2'd0);
    applyStimulus(1, 4'b0000, 0);
    checkOutput("tie_processing", 4'b0000, 4'b0000, 0, 1, 2'd0);
    to_seen = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 4'b0000, 0);
      if (timeout) to_seen = 1;
    end
    checkValue("tie_no_timeout", 32'(to_seen), 32'd0);
    checkValue("tie_done", 32'(done), 32'b0001);

    // Reset during processing: no done afterwards, rr_ptr back to 0.
    applyStimulus(0, 4'b0000, 0);
    applyStimulus(1, 4'b0100, 0);
    applyStimulus(1, 4'b0000, 0);
    applyStimulus(1, 4'b0000, 0);
    checkValue("rst_pre_busy", 32'(busy), 32'd1);
    applyStimulus(0, 4'b0000, 0);
    checkOutput("rst_mid", 4'b0000, 4'b0000, 0, 0, 2'd0);
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 4'b0000, 0);
      if (done != 4'b0000) done_seen = 1;
    end
    checkValue("rst_no_done", 32'(done_seen), 32'd0);
    applyStimulus(1, 4'b1111, 0);
    checkOutput("rst_ptr_zero", 4'b0001, 4'b0000, 0, 1, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
